// File: rtl/ray_core_arbiter.sv
// ray_core_arbiter: frame scheduler and round-robin merge of ray-generator cores into one stream
module ray_core_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DIR_W     = 32,
    parameter int IDX_W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [12:0]                image_width,
    input  logic [12:0]                image_height,
    output logic                       cores_start,
    input  logic [NUM_CORES-1:0]       core_valid,
    output logic [NUM_CORES-1:0]       core_ready,
    input  logic [NUM_CORES*DIR_W-1:0] core_dir_x,
    input  logic [NUM_CORES*DIR_W-1:0] core_dir_y,
    input  logic [NUM_CORES*DIR_W-1:0] core_dir_z,
    input  logic [NUM_CORES*IDX_W-1:0] core_index,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIR_W-1:0]           out_dir_x,
    output logic [DIR_W-1:0]           out_dir_y,
    output logic [DIR_W-1:0]           out_dir_z,
    output logic [IDX_W-1:0]           out_index,
    output logic [2:0]                 out_core_id,
    output logic                       frame_busy,
    output logic                       frame_done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [25:0]      total, count, frame_size;
    logic [2:0]       rr_ptr, grant, idx;
    logic [3:0]       sum;
    logic [7:0]       valid_pad;
    logic             hit, take;
    logic [DIR_W-1:0] sel_x, sel_y, sel_z;
    logic [IDX_W-1:0] sel_index;

    assign frame_size = 26'(image_width) * 26'(image_height);
    assign valid_pad  = 8'(core_valid);
    assign take       = (state == RUN) && (!out_valid || out_ready) && hit;
    assign core_ready = take ? NUM_CORES'(8'd1 << grant) : '0;

    // first valid core scanning upward from rr_ptr with wrap; lowest offset wins
    always_comb begin
        hit   = 1'b0;
        grant = '0;
        sum   = '0;
        idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + 4'(i);
            idx = (sum >= 4'(NUM_CORES)) ? 3'(sum - 4'(NUM_CORES)) : sum[2:0];
            if (valid_pad[idx]) begin
                hit   = 1'b1;
                grant = idx;
            end
        end
    end

    // payload of the granted core, kept off the core_ready path
    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_z     = '0;
        sel_index = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (grant == 3'(k)) begin
                sel_x     = core_dir_x[k*DIR_W +: DIR_W];
                sel_y     = core_dir_y[k*DIR_W +: DIR_W];
                sel_z     = core_dir_z[k*DIR_W +: DIR_W];
                sel_index = core_index[k*IDX_W +: IDX_W];
            end
        end
    end

    // frame FSM, ray counter and output register; an empty frame still passes through DONE twice so frame_done lands two cycles after start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            total       <= '0;
            count       <= '0;
            rr_ptr      <= '0;
            cores_start <= 1'b0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            out_valid   <= 1'b0;
            out_dir_x   <= '0;
            out_dir_y   <= '0;
            out_dir_z   <= '0;
            out_index   <= '0;
            out_core_id <= '0;
        end else begin
            cores_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        total       <= frame_size;
                        count       <= '0;
                        rr_ptr      <= '0;
                        cores_start <= 1'b1;
                        frame_busy  <= 1'b1;
                        state       <= (frame_size == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (take) begin
                        out_valid   <= 1'b1;
                        out_dir_x   <= sel_x;
                        out_dir_y   <= sel_y;
                        out_dir_z   <= sel_z;
                        out_index   <= sel_index;
                        out_core_id <= grant;
                        rr_ptr      <= (grant == 3'(NUM_CORES - 1)) ? 3'd0 : grant + 3'd1;
                        count       <= count + 26'd1;
                        if (count + 26'd1 == total)
                            state <= DRAIN;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!out_valid || out_ready) begin
                        out_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (frame_busy) begin
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ray_core_arbiter.sv
// tb_ray_core_arbiter: directed frames against a cycle model plus hand-computed checkpoints
module tb_ray_core_arbiter;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_ZERO = 3, P_FIN = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         oready = 1'b1;
    logic [12:0]  wdt = '0, hgt = '0;
    logic [3:0]   cvalid = '0;
    logic [127:0] dx = '0, dy = '0, dz = '0, cidx = '0;
    logic         cstart, ovalid, busy, done;
    logic [3:0]   cready;
    logic [31:0]  ox, oy, oz, oidx;
    logic [2:0]   oid;

    logic         s1_start = 1'b0;
    logic [12:0]  s1_w = '0, s1_h = '0;
    logic [0:0]   s1_valid = 1'b0;
    logic         s1_oready = 1'b1;
    logic         s1_cstart, s1_ovalid, s1_busy, s1_done;
    logic [0:0]   s1_cready;
    logic [31:0]  s1_ox, s1_oy, s1_oz, s1_oidx;
    logic [2:0]   s1_oid;

    int n_tests = 0, n_fail = 0, cyc = 0;
    int beats[$];

    int          m_ph = P_IDLE, m_left = 0, m_ptr = 0, g;
    logic [3:0]  er;
    logic        e_valid = 0, e_busy = 0, e_done = 0, e_cstart = 0;
    logic [31:0] e_x = 0, e_y = 0, e_z = 0, e_idx = 0;
    logic [2:0]  e_id = 0;

    ray_core_arbiter #(.NUM_CORES(4), .DIR_W(32), .IDX_W(32)) u4 (
        .clk(clk), .reset(reset), .start(start), .image_width(wdt), .image_height(hgt),
        .cores_start(cstart), .core_valid(cvalid), .core_ready(cready),
        .core_dir_x(dx), .core_dir_y(dy), .core_dir_z(dz), .core_index(cidx),
        .out_valid(ovalid), .out_ready(oready), .out_dir_x(ox), .out_dir_y(oy), .out_dir_z(oz),
        .out_index(oidx), .out_core_id(oid), .frame_busy(busy), .frame_done(done)
    );

    ray_core_arbiter #(.NUM_CORES(1), .DIR_W(32), .IDX_W(32)) u1 (
        .clk(clk), .reset(reset), .start(s1_start), .image_width(s1_w), .image_height(s1_h),
        .cores_start(s1_cstart), .core_valid(s1_valid), .core_ready(s1_cready),
        .core_dir_x(dx[31:0]), .core_dir_y(dy[31:0]), .core_dir_z(dz[31:0]), .core_index(cidx[31:0]),
        .out_valid(s1_ovalid), .out_ready(s1_oready), .out_dir_x(s1_ox), .out_dir_y(s1_oy), .out_dir_z(s1_oz),
        .out_index(s1_oidx), .out_core_id(s1_oid), .frame_busy(s1_busy), .frame_done(s1_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 4; k++) begin
            dx[k*32 +: 32]   = cyc * 16 + k;
            dy[k*32 +: 32]   = -(cyc * 16 + k);
            dz[k*32 +: 32]   = (cyc << 8) ^ k ^ 32'h00a5_0000;
            cidx[k*32 +: 32] = cyc * 4 + k;
        end
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("frame_done_wait", done, 1);
        step();
    endtask

    // cycle model of the 4-core instance: compare current outputs, then advance on the sampled inputs
    always @(negedge clk) begin
        if (reset) begin
            m_ph = P_IDLE; m_left = 0; m_ptr = 0;
            e_valid = 0; e_busy = 0; e_done = 0; e_cstart = 0;
            e_x = 0; e_y = 0; e_z = 0; e_idx = 0; e_id = 0;
        end
        g = -1;
        if (!reset && m_ph == P_RUN && (!e_valid || oready))
            for (int k = 0; k < 4; k++)
                if (g < 0 && cvalid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        er = (g < 0) ? 4'b0 : 4'(1 << g);
        chk("core_ready", cready, er);
        chk("out_valid", ovalid, e_valid);
        chk("frame_busy", busy, e_busy);
        chk("frame_done", done, e_done);
        chk("cores_start", cstart, e_cstart);
        chk("out_dir_x", ox, e_x);
        chk("out_dir_y", oy, e_y);
        chk("out_dir_z", oz, e_z);
        chk("out_index", oidx, e_idx);
        chk("out_core_id", oid, e_id);
        if (!reset) begin
            if (ovalid && oready) beats.push_back(int'(oid));
            e_cstart = 0;
            e_done = 0;
            case (m_ph)
                P_IDLE: if (start) begin
                    m_left = int'(wdt) * int'(hgt);
                    m_ptr = 0; e_cstart = 1; e_busy = 1;
                    m_ph = (m_left == 0) ? P_ZERO : P_RUN;
                end
                P_RUN: begin
                    if (g >= 0) begin
                        e_valid = 1;
                        e_x = dx[g*32 +: 32]; e_y = dy[g*32 +: 32]; e_z = dz[g*32 +: 32];
                        e_idx = cidx[g*32 +: 32]; e_id = 3'(g);
                        m_ptr = (g + 1) % 4;
                        m_left--;
                        if (m_left == 0) m_ph = P_DRAIN;
                    end else if (e_valid && oready) e_valid = 0;
                end
                P_DRAIN: if (!e_valid || oready) begin
                    e_valid = 0; e_done = 1; e_busy = 0; m_ph = P_FIN;
                end
                P_ZERO: begin e_done = 1; e_busy = 0; m_ph = P_FIN; end
                default: m_ph = P_IDLE;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ex8[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int ex5[5] = '{1, 3, 1, 3, 1};
        logic [8:1] a_ov, a_fd, a_cr, a_cs, a_bz;
        int c_hold;

        step();
        @(negedge clk);
        chk("reset_out_valid", ovalid, 0);
        chk("reset_frame_busy", busy, 0);
        chk("reset_s1_core_ready", s1_cready, 0);
        step();
        reset = 1'b0;
        step();

        // single-core 2x2 frame
        s1_valid = 1'b1; s1_w = 13'd2; s1_h = 13'd2; s1_start = 1'b1;
        step();
        s1_start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            a_ov[c] = s1_ovalid; a_fd[c] = s1_done; a_cr[c] = s1_cready[0];
            a_cs[c] = s1_cstart; a_bz[c] = s1_busy;
            step();
        end
        chk("c1_out_valid_beats", a_ov, 8'b0001_1110);
        chk("c1_frame_done", a_fd, 8'b0010_0000);
        chk("c1_core_ready", a_cr, 8'b0000_1111);
        chk("c1_cores_start", a_cs, 8'b0000_0001);
        chk("c1_frame_busy", a_bz, 8'b0001_1111);
        s1_valid = 1'b0;

        // four cores all valid, 4x2 frame
        beats.delete();
        cvalid = 4'b1111; oready = 1'b1; wdt = 13'd4; hgt = 13'd2; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(40);
        chk("rr_beat_count", beats.size(), 8);
        for (int i = 0; i < 8 && i < beats.size(); i++) chk("rr_core_id", beats[i], ex8[i]);

        // backpressure with a pending ray
        wdt = 13'd4; hgt = 13'd4; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        c_hold = cyc;
        step();
        oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", ovalid, 1);
            chk("bp_core_ready", cready, 0);
            chk("bp_held_x", ox, 32'(c_hold * 16 + 2));
            chk("bp_held_id", oid, 2);
            step();
        end
        oready = 1'b1;
        @(negedge clk);
        chk("bp_regrant", cready, 4'b1000);
        wait_done(60);

        // sparse valid: cores 1 and 3 after the pointer moves to 2
        beats.delete();
        cvalid = 4'b0010; wdt = 13'd5; hgt = 13'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        cvalid = 4'b1010;
        wait_done(40);
        chk("sparse_count", beats.size(), 5);
        for (int i = 0; i < 5 && i < beats.size(); i++) chk("sparse_core_id", beats[i], ex5[i]);
        cvalid = 4'b1111;

        // zero-width frame
        beats.delete();
        wdt = 13'd0; hgt = 13'd5; start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("zero_cores_start", cstart, 1);
        chk("zero_done_early", done, 0);
        step();
        @(negedge clk);
        chk("zero_frame_done", done, 1);
        chk("zero_busy", busy, 0);
        step();
        chk("zero_rays", beats.size(), 0);

        // start during RUN is ignored
        beats.delete();
        wdt = 13'd3; hgt = 13'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1; wdt = 13'd7;
        step();
        start = 1'b0;
        wait_done(40);
        step();
        chk("ignore_start_count", beats.size(), 3);
        chk("ignore_start_idle", busy, 0);

        // reset mid-frame after three rays
        beats.delete();
        wdt = 13'd4; hgt = 13'd4; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && beats.size() < 3; i++) step();
        chk("pre_reset_beats", beats.size(), 3);
        reset = 1'b1;
        #1;
        chk("rst_out_valid", ovalid, 0);
        chk("rst_core_ready", cready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_x", ox, 0);
        chk("rst_out_id", oid, 0);
        step();
        reset = 1'b0;
        beats.delete();
        wdt = 13'd2; hgt = 13'd1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(40);
        chk("post_reset_count", beats.size(), 2);
        if (beats.size() == 2) begin
            chk("post_reset_id0", beats[0], 0);
            chk("post_reset_id1", beats[1], 1);
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
